uart_rx_subsystem: RTL and testbench
====================================

UART_RX_SUBSYSTEM -- requirements
Module: uart_rx_subsystem

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame.
REQ-002 Parameter SB_TICK, default 16: stop-bit length in oversample ticks (16 = 1 bit, 24 = 1.5 bits, 32 = 2 bits).
REQ-003 Parameter DVSR, default 1: baud divisor; one oversample tick every DVSR+1 clocks.
REQ-004 Parameter DVSR_BIT, default 4: width of the divisor counter.
REQ-005 Parameter FIFO_W, default 2: FIFO address bits; depth = 2^FIFO_W words.
REQ-006 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-007 i_reset_n  in  1  asynchronous, active-low reset.
REQ-008 i_rx  in  1  serial line; idles high.
REQ-009 i_rd_uart  in  1  pop request, sampled each clock.
REQ-010 o_rd_data  out  DBIT  head-of-FIFO word (first-word fall-through).
REQ-011 o_rx_empty  out  1  FIFO holds 0 words.
REQ-012 o_rx_full  out  1  FIFO holds 2^FIFO_W words.
REQ-013 o_tick  out  1  oversample tick, one clock wide.
REQ-014 o_rx_done_tick  out  1  one-clock pulse when a frame completes.

Function
REQ-015 Baud generator: DVSR_BIT-bit counter counts 0..DVSR then wraps to 0; o_tick = 1 while count == DVSR (period DVSR+1 clocks; DVSR=1 gives tick high on every second clock).
REQ-016 Receiver FSM states: IDLE, START, DATA, STOP; it keeps a 4-bit tick counter s, a bit counter n and a DBIT-bit shift register b.
REQ-017 IDLE: when i_rx = 0, go to START with s = 0; the falling edge is detected on any clock, independent of o_tick.
REQ-018 START: on each tick, if s == 7 go to DATA with s = 0 and n = 0; otherwise s increments. This samples mid-bit.
REQ-019 DATA: on each tick, if s == 15 then s = 0 and b = {i_rx, b[DBIT-1:1]} (LSB first); if n == DBIT-1 go to STOP, otherwise n increments. If s != 15, s increments.
REQ-020 STOP: on each tick, if s == SB_TICK-1 go to IDLE and assert o_rx_done_tick for exactly that one clock; otherwise s increments. The stop-bit value is not checked (no framing error).
REQ-021 The received word equals b and is written to the FIFO on o_rx_done_tick.
REQ-022 FIFO write when not full: store at the write pointer and advance it. A write while full (with no read) is dropped silently.
REQ-023 FIFO read when not empty: advance the read pointer. A read while empty is ignored.
REQ-024 Simultaneous write and read while full: both occur and the FIFO stays full. While empty: only the write occurs. Otherwise: both occur and the count is unchanged.
REQ-025 Pointers wrap modulo 2^FIFO_W.
REQ-026 Flags are registered: empty sets when a read makes r_ptr equal w_ptr; full sets when a write makes w_ptr equal r_ptr.
REQ-027 o_rd_data = mem[r_ptr] combinationally. The value is undefined while empty.

Reset
REQ-028 Asserting i_reset_n low immediately clears the baud counter, FSM (to IDLE), s, n, b, and FIFO pointers.
REQ-029 During reset: o_tick = 0, o_rx_done_tick = 0, o_rx_empty = 1, o_rx_full = 0.
REQ-030 Reset mid-frame discards the partial frame. FIFO memory contents need not be cleared.

Structure
REQ-031 Shared package uart_pkg holds the default parameter constants and the FSM state enum.
REQ-032 The FIFO is one sub-module, sync_fifo (parameters B, W). The baud counter and receiver FSM are inline in uart_rx_subsystem.

Verification
REQ-033 Reset, then DVSR=1 -> o_tick toggles: high 1 clock, low 1 clock; flags empty=1, full=0.
REQ-034 Send frame 0x05 (16 ticks per bit, LSB first, 1 stop bit), then pulse i_rd_uart -> o_rx_done_tick pulses once; o_rd_data = 0x05 before the pop; empty = 1 after.
REQ-035 Send 0x00, 0x14, 0xAA, 0xFF -> full = 1 after the 4th frame; send 0x32 -> done pulse occurs but the word is dropped and full stays 1.
REQ-036 Pop 5 times -> data read 0x00, 0x14, 0xAA, 0xFF; full clears after the first pop; empty = 1 after the 4th; the 5th pop changes nothing.
REQ-037 Drive i_rx low for fewer than 8 ticks, then high -> no mis-sync crash; the frame completes as data and is accepted; a reset mid-DATA returns the FSM to IDLE with no done pulse.
REQ-038 Simultaneous write and pop with the FIFO full -> count unchanged, full stays 1, order preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults and receiver state encoding for the UART receive subsystem.
package uart_pkg;
    localparam int DBIT_DEF     = 8;
    localparam int SB_TICK_DEF  = 16;
    localparam int DVSR_DEF     = 1;
    localparam int DVSR_BIT_DEF = 4;
    localparam int FIFO_W_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered empty/full flags.
module sync_fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full
);
    logic [B-1:0] mem [2**W];
    logic [W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [W-1:0] w_succ, r_succ;
    logic         empty_q, empty_d, full_q, full_d;
    logic         wr_en;

    // A write while full is accepted only when a read frees the head slot in the same clock.
    assign wr_en  = wr & (~full_q | rd);
    assign w_succ = w_ptr_q + 1'b1;
    assign r_succ = r_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr_q] <= w_data;
        end
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        empty_d = empty_q;
        full_d  = full_q;
        case ({wr, rd})
            2'b01: begin
                if (!empty_q) begin
                    r_ptr_d = r_succ;
                    full_d  = 1'b0;
                    if (r_succ == w_ptr_q) empty_d = 1'b1;
                end
            end
            2'b10: begin
                if (!full_q) begin
                    w_ptr_d = w_succ;
                    empty_d = 1'b0;
                    if (w_succ == r_ptr_q) full_d = 1'b1;
                end
            end
            2'b11: begin
                if (empty_q) begin
                    w_ptr_d = w_succ;
                    empty_d = 1'b0;
                    full_d  = (w_succ == r_ptr_q);
                end else begin
                    w_ptr_d = w_succ;
                    r_ptr_d = r_succ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign r_data = mem[r_ptr_q];
    assign empty  = empty_q;
    assign full   = full_q;
endmodule

// File: rtl/uart_rx_subsystem.sv
// UART receiver: baud tick generator, 16x oversampling receive FSM and a receive FIFO.
module uart_rx_subsystem
    import uart_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int SB_TICK  = SB_TICK_DEF,
    parameter int DVSR     = DVSR_DEF,
    parameter int DVSR_BIT = DVSR_BIT_DEF,
    parameter int FIFO_W   = FIFO_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_rx,
    input  logic            i_rd_uart,
    output logic [DBIT-1:0] o_rd_data,
    output logic            o_rx_empty,
    output logic            o_rx_full,
    output logic            o_tick,
    output logic            o_rx_done_tick
);
    // Tick counter widens to 5 bits so 1.5/2 stop-bit lengths (24/32 ticks) are reachable.
    localparam int S_W = (SB_TICK > 16) ? 5 : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [DVSR_BIT-1:0] DVSR_V = DVSR_BIT'(DVSR);

    logic [DVSR_BIT-1:0] baud_q, baud_d;
    logic                tick;

    rx_state_e           state_q, state_d;
    logic [S_W-1:0]      s_q, s_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic                done;

    assign tick = (baud_q == DVSR_V);

    always_comb begin
        baud_d = tick ? '0 : baud_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_rx) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_W'(7)) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d = '0;
                        b_d = {i_rx, b_q[DBIT-1:1]};
                        if (n_q == N_W'(DBIT - 1)) state_d = STOP;
                        else                       n_d     = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            baud_q  <= '0;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            baud_q  <= baud_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    sync_fifo #(
        .B (DBIT),
        .W (FIFO_W)
    ) u_fifo (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .rd     (i_rd_uart),
        .wr     (done),
        .w_data (b_q),
        .r_data (o_rd_data),
        .empty  (o_rx_empty),
        .full   (o_rx_full)
    );

    assign o_tick         = tick;
    assign o_rx_done_tick = done;
endmodule

// File: tb/tb_uart_rx_subsystem.sv
// Directed bench for uart_rx_subsystem with default parameters (DVSR=1, 8N1, 4-deep FIFO).
module tb_uart_rx_subsystem;
    logic       i_clk;
    logic       i_reset_n;
    logic       i_rx;
    logic       i_rd_uart;
    logic [7:0] o_rd_data;
    logic       o_rx_empty;
    logic       o_rx_full;
    logic       o_tick;
    logic       o_rx_done_tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int d0;
    logic prev_tick;

    uart_rx_subsystem #(
        .DBIT     (8),
        .SB_TICK  (16),
        .DVSR     (1),
        .DVSR_BIT (4),
        .FIFO_W   (2)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_rx           (i_rx),
        .i_rd_uart      (i_rd_uart),
        .o_rd_data      (o_rd_data),
        .o_rx_empty     (o_rx_empty),
        .o_rx_full      (o_rx_full),
        .o_tick         (o_tick),
        .o_rx_done_tick (o_rx_done_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_rx_done_tick === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic pop();
        i_rd_uart = 1'b1;
        wait_clks(1);
        i_rd_uart = 1'b0;
    endtask

    // 32 clocks per bit = 16 ticks at DVSR=1; optionally pops in the done clock.
    task automatic send_frame(input logic [7:0] d, input bit pop_at_done);
        i_rx = 1'b0;
        wait_clks(32);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            wait_clks(32);
        end
        i_rx = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge i_clk);
            if (pop_at_done && o_rx_done_tick) i_rd_uart = 1'b1;
            @(posedge i_clk);
            #1;
            i_rd_uart = 1'b0;
        end
        wait_clks(8);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_rx      = 1'b1;
        i_rd_uart = 1'b0;
        wait_clks(3);
        check("rst_tick",  {31'd0, o_tick}, 32'd0);
        check("rst_done",  {31'd0, o_rx_done_tick}, 32'd0);
        check("rst_empty", {31'd0, o_rx_empty}, 32'd1);
        check("rst_full",  {31'd0, o_rx_full}, 32'd0);
        i_reset_n = 1'b1;

        wait_clks(1);
        prev_tick = o_tick;
        for (int i = 0; i < 4; i++) begin
            wait_clks(1);
            check("tick_toggle", {31'd0, o_tick}, {31'd0, ~prev_tick});
            prev_tick = o_tick;
        end
        check("idle_empty", {31'd0, o_rx_empty}, 32'd1);
        check("idle_full",  {31'd0, o_rx_full}, 32'd0);

        d0 = done_cnt;
        send_frame(8'h05, 1'b0);
        check("f05_done_cnt", done_cnt - d0, 32'd1);
        check("f05_data",  {24'd0, o_rd_data}, 32'h05);
        check("f05_empty", {31'd0, o_rx_empty}, 32'd0);
        pop();
        check("f05_empty_after_pop", {31'd0, o_rx_empty}, 32'd1);

        send_frame(8'h00, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'hAA, 1'b0);
        check("fill3_full", {31'd0, o_rx_full}, 32'd0);
        send_frame(8'hFF, 1'b0);
        check("fill4_full", {31'd0, o_rx_full}, 32'd1);
        d0 = done_cnt;
        send_frame(8'h32, 1'b0);
        check("drop_done_cnt", done_cnt - d0, 32'd1);
        check("drop_full", {31'd0, o_rx_full}, 32'd1);
        check("drop_head", {24'd0, o_rd_data}, 32'h00);

        check("pop1_data", {24'd0, o_rd_data}, 32'h00);
        pop();
        check("pop1_full", {31'd0, o_rx_full}, 32'd0);
        check("pop2_data", {24'd0, o_rd_data}, 32'h14);
        pop();
        check("pop3_data", {24'd0, o_rd_data}, 32'hAA);
        pop();
        check("pop3_empty", {31'd0, o_rx_empty}, 32'd0);
        check("pop4_data", {24'd0, o_rd_data}, 32'hFF);
        pop();
        check("pop4_empty", {31'd0, o_rx_empty}, 32'd1);
        pop();
        check("pop5_empty", {31'd0, o_rx_empty}, 32'd1);
        check("pop5_full",  {31'd0, o_rx_full}, 32'd0);

        // Short low pulse: FSM commits to a frame and samples idle-high data bits.
        d0 = done_cnt;
        i_rx = 1'b0;
        wait_clks(8);
        i_rx = 1'b1;
        wait_clks(340);
        check("glitch_done_cnt", done_cnt - d0, 32'd1);
        check("glitch_data",  {24'd0, o_rd_data}, 32'hFF);
        check("glitch_empty", {31'd0, o_rx_empty}, 32'd0);

        // Reset while in DATA: partial frame and FIFO pointers are discarded.
        d0 = done_cnt;
        i_rx = 1'b0;
        wait_clks(32);
        wait_clks(64);
        i_reset_n = 1'b0;
        wait_clks(2);
        check("midrst_empty", {31'd0, o_rx_empty}, 32'd1);
        check("midrst_done",  {31'd0, o_rx_done_tick}, 32'd0);
        check("midrst_tick",  {31'd0, o_tick}, 32'd0);
        i_rx = 1'b1;
        i_reset_n = 1'b1;
        wait_clks(400);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_still_empty", {31'd0, o_rx_empty}, 32'd1);

        // Write coincident with pop while full.
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        send_frame(8'h44, 1'b0);
        check("sim_pre_full", {31'd0, o_rx_full}, 32'd1);
        d0 = done_cnt;
        send_frame(8'h55, 1'b1);
        check("sim_done_cnt", done_cnt - d0, 32'd1);
        check("sim_full", {31'd0, o_rx_full}, 32'd1);
        check("sim_head", {24'd0, o_rd_data}, 32'h22);
        pop();
        check("sim_d2", {24'd0, o_rd_data}, 32'h33);
        pop();
        check("sim_d3", {24'd0, o_rd_data}, 32'h44);
        pop();
        check("sim_d4", {24'd0, o_rd_data}, 32'h55);
        check("sim_not_empty", {31'd0, o_rx_empty}, 32'd0);
        pop();
        check("sim_empty", {31'd0, o_rx_empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
